// File: rtl/btn_pkg.sv
// Shared types and default timing constants for the push-button conditioner.
package btn_pkg;

  // Per-channel hold tracking: released, held before long-press, auto-repeating.
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    DOWN = 2'd1,
    RPT  = 2'd2
  } btn_state_t;

  // Defaults assume a 100 MHz system clock.
  localparam int DEBOUNCE_CYCLES_DEF = 1_000_000;  // 10 ms
  localparam int LONG_CYCLES_DEF     = 50_000_000; // 0.5 s
  localparam int REPEAT_CYCLES_DEF   = 10_000_000; // 0.1 s

  // Larger of two integers, used to size the shared hold counter.
  function automatic int max_int(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/btn_conditioner_if.sv
// Bundle of raw button pins and the conditioned level/strobe outputs.
// master: the side that owns the pins and consumes the strobes.
// slave:  the conditioner itself.
interface btn_conditioner_if #(
  parameter int N_BTN = 3
);
  logic [N_BTN-1:0] BTN;
  logic [N_BTN-1:0] BTN_LEVEL;
  logic [N_BTN-1:0] BTN_PRESS;
  logic [N_BTN-1:0] BTN_RELEASE;
  logic [N_BTN-1:0] BTN_LONG;
  logic [N_BTN-1:0] BTN_REPEAT;

  modport master (
    output BTN,
    input  BTN_LEVEL, BTN_PRESS, BTN_RELEASE, BTN_LONG, BTN_REPEAT
  );

  modport slave (
    input  BTN,
    output BTN_LEVEL, BTN_PRESS, BTN_RELEASE, BTN_LONG, BTN_REPEAT
  );
endinterface

// File: rtl/btn_channel.sv
// One button: 2-FF synchronizer, debounce counter and press/long/repeat FSM.
// Every output is a flop; nothing from btn_raw_i reaches an output combinationally.
module btn_channel
  import btn_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF,
  parameter int LONG_CYCLES     = LONG_CYCLES_DEF,
  parameter int REPEAT_CYCLES   = REPEAT_CYCLES_DEF
) (
  input  logic clk,
  input  logic rst,
  input  logic btn_raw_i,
  output logic level_o,
  output logic press_o,
  output logic release_o,
  output logic long_o,
  output logic repeat_o
);

  localparam int DW = $clog2(DEBOUNCE_CYCLES);
  localparam int HW = $clog2(max_int(LONG_CYCLES, REPEAT_CYCLES));

  localparam logic [DW-1:0] DEB_LAST  = DW'(DEBOUNCE_CYCLES - 1);
  localparam logic [HW-1:0] LONG_LAST = HW'(LONG_CYCLES - 1);
  localparam logic [HW-1:0] RPT_LAST  = HW'(REPEAT_CYCLES - 1);

  logic          sync1_q, sync2_q;
  logic [DW-1:0] deb_cnt_q, deb_cnt_d;
  logic          level_q, level_d;
  logic          deb_rise, deb_fall;

  btn_state_t    state_q, state_d;
  logic [HW-1:0] hold_cnt_q, hold_cnt_d;
  logic          press_q, press_d;
  logic          release_q, release_d;
  logic          long_q, long_d;
  logic          repeat_q, repeat_d;

  // Bring the asynchronous pin into the clock domain.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
    end else begin
      sync1_q <= btn_raw_i;
      sync2_q <= sync1_q;
    end
  end

  // Count consecutive disagreeing cycles; any agreeing cycle restarts the count.
  always_comb begin
    deb_cnt_d = '0;
    level_d   = level_q;
    deb_rise  = 1'b0;
    deb_fall  = 1'b0;
    if (sync2_q != level_q) begin
      if (deb_cnt_q == DEB_LAST) begin
        level_d  = sync2_q;
        deb_rise = sync2_q;
        deb_fall = ~sync2_q;
      end else begin
        deb_cnt_d = deb_cnt_q + 1'b1;
      end
    end
  end

  // Debounce state: counter and accepted level.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      deb_cnt_q <= '0;
      level_q   <= 1'b0;
    end else begin
      deb_cnt_q <= deb_cnt_d;
      level_q   <= level_d;
    end
  end

  // Hold FSM next state; an accepted fall pre-empts a LONG/REPEAT threshold.
  always_comb begin
    state_d    = state_q;
    hold_cnt_d = hold_cnt_q;
    press_d    = 1'b0;
    release_d  = 1'b0;
    long_d     = 1'b0;
    repeat_d   = 1'b0;
    case (state_q)
      IDLE: begin
        hold_cnt_d = '0;
        if (deb_rise) begin
          state_d = DOWN;
          press_d = 1'b1;
        end
      end
      DOWN: begin
        if (deb_fall) begin
          state_d    = IDLE;
          hold_cnt_d = '0;
          release_d  = 1'b1;
        end else if (hold_cnt_q == LONG_LAST) begin
          state_d    = RPT;
          hold_cnt_d = '0;
          long_d     = 1'b1;
        end else begin
          hold_cnt_d = hold_cnt_q + 1'b1;
        end
      end
      RPT: begin
        if (deb_fall) begin
          state_d    = IDLE;
          hold_cnt_d = '0;
          release_d  = 1'b1;
        end else if (hold_cnt_q == RPT_LAST) begin
          hold_cnt_d = '0;
          repeat_d   = 1'b1;
        end else begin
          hold_cnt_d = hold_cnt_q + 1'b1;
        end
      end
      default: begin
        state_d    = IDLE;
        hold_cnt_d = '0;
      end
    endcase
  end

  // Hold FSM state, counter and registered strobes.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      hold_cnt_q <= '0;
      press_q    <= 1'b0;
      release_q  <= 1'b0;
      long_q     <= 1'b0;
      repeat_q   <= 1'b0;
    end else begin
      state_q    <= state_d;
      hold_cnt_q <= hold_cnt_d;
      press_q    <= press_d;
      release_q  <= release_d;
      long_q     <= long_d;
      repeat_q   <= repeat_d;
    end
  end

  assign level_o   = level_q;
  assign press_o   = press_q;
  assign release_o = release_q;
  assign long_o    = long_q;
  assign repeat_o  = repeat_q;

endmodule

// File: rtl/btn_conditioner.sv
// Push-button conditioner: N_BTN independent debounce/hold channels.
module btn_conditioner
  import btn_pkg::*;
#(
  parameter int N_BTN           = 3,
  parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF,
  parameter int LONG_CYCLES     = LONG_CYCLES_DEF,
  parameter int REPEAT_CYCLES   = REPEAT_CYCLES_DEF
) (
  input logic              CLK100MHZ,
  input logic              RST,
  btn_conditioner_if.slave bus
);

  // Counters compare against N-1 and need at least one bit of range.
  if (DEBOUNCE_CYCLES < 2 || LONG_CYCLES < 2 || REPEAT_CYCLES < 2) begin : g_param_check
    $error("btn_conditioner: DEBOUNCE_CYCLES, LONG_CYCLES and REPEAT_CYCLES must be >= 2");
  end

  logic [N_BTN-1:0] level_w;
  logic [N_BTN-1:0] press_w;
  logic [N_BTN-1:0] release_w;
  logic [N_BTN-1:0] long_w;
  logic [N_BTN-1:0] repeat_w;

  for (genvar gi = 0; gi < N_BTN; gi++) begin : g_ch
    btn_channel #(
      .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
      .LONG_CYCLES     (LONG_CYCLES),
      .REPEAT_CYCLES   (REPEAT_CYCLES)
    ) u_channel (
      .clk       (CLK100MHZ),
      .rst       (RST),
      .btn_raw_i (bus.BTN[gi]),
      .level_o   (level_w[gi]),
      .press_o   (press_w[gi]),
      .release_o (release_w[gi]),
      .long_o    (long_w[gi]),
      .repeat_o  (repeat_w[gi])
    );
  end

  assign bus.BTN_LEVEL   = level_w;
  assign bus.BTN_PRESS   = press_w;
  assign bus.BTN_RELEASE = release_w;
  assign bus.BTN_LONG    = long_w;
  assign bus.BTN_REPEAT  = repeat_w;

endmodule

// File: tb/tb_btn_conditioner.sv
// Bench for btn_conditioner: directed timing sequences, a table of multi-channel
// vectors, and random stimulus, all cross-checked every cycle against a
// time-based reference model.
module tb_btn_conditioner;

  localparam int N    = 3;
  localparam int DEB  = 4;
  localparam int LONG = 10;
  localparam int REP  = 3;
  localparam int HW   = DEB + 2;  // raw-sample history: 2 sync stages + debounce window

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks = 0;
  int   errors = 0;

  btn_conditioner_if #(.N_BTN(N)) bus ();

  btn_conditioner #(
    .N_BTN           (N),
    .DEBOUNCE_CYCLES (DEB),
    .LONG_CYCLES     (LONG),
    .REPEAT_CYCLES   (REP)
  ) dut (
    .CLK100MHZ (clk),
    .RST       (rst),
    .bus       (bus)
  );

  always #5 clk = ~clk;

  function automatic void chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endfunction

  // ---------------- reference model ----------------
  // A level is accepted once the synchronized input (raw delayed 2 cycles) has
  // disagreed with it for DEB consecutive cycles. Long/repeat strobes follow
  // from the elapsed cycles since the accepted press.
  logic [HW-1:0] hist [N];
  logic [N-1:0]  m_level, m_press, m_release, m_long, m_repeat;
  int            m_cyc;
  int            press_at [N];

  function automatic void model_clear();
    for (int ch = 0; ch < N; ch++) begin
      hist[ch]     = '0;
      press_at[ch] = 0;
    end
    m_level = '0; m_press = '0; m_release = '0; m_long = '0; m_repeat = '0;
    m_cyc = 0;
  endfunction

  always @(posedge clk) begin
    if (rst) begin
      model_clear();
    end else begin
      m_cyc++;
      m_press = '0; m_release = '0; m_long = '0; m_repeat = '0;
      for (int ch = 0; ch < N; ch++) begin
        hist[ch] = {hist[ch][HW-2:0], bus.BTN[ch]};
        if (hist[ch][HW-1:2] == {DEB{~m_level[ch]}}) begin
          m_level[ch] = ~m_level[ch];
          if (m_level[ch]) begin
            m_press[ch]  = 1'b1;
            press_at[ch] = m_cyc;
          end else begin
            m_release[ch] = 1'b1;
          end
        end else if (m_level[ch]) begin
          int d;
          d = m_cyc - press_at[ch];
          m_long[ch]   = (d == LONG);
          m_repeat[ch] = (d > LONG) && (((d - LONG) % REP) == 0);
        end
      end
    end
  end

  always @(negedge clk) begin
    if (rst) model_clear();
    chk("sb_level",   int'(bus.BTN_LEVEL),   int'(m_level));
    chk("sb_press",   int'(bus.BTN_PRESS),   int'(m_press));
    chk("sb_release", int'(bus.BTN_RELEASE), int'(m_release));
    chk("sb_long",    int'(bus.BTN_LONG),    int'(m_long));
    chk("sb_repeat",  int'(bus.BTN_REPEAT),  int'(m_repeat));
  end

  // ---------------- stimulus helpers ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst     = 1'b1;
    bus.BTN = '0;
    tick();
    tick();
    rst = 1'b0;
    tick();
  endtask

  // Tick until any masked press strobe appears (bounded); n = ticks taken or -1.
  task automatic wait_press(input logic [N-1:0] mask, output int n,
                            output logic [N-1:0] seen, output int rel_cnt);
    n = -1;
    seen = '0;
    rel_cnt = 0;
    for (int i = 1; i <= 20; i++) begin
      tick();
      rel_cnt += $countones(bus.BTN_RELEASE);
      if ((bus.BTN_PRESS & mask) != '0) begin
        n = i;
        seen = bus.BTN_PRESS;
        break;
      end
    end
  endtask

  typedef struct {
    logic [N-1:0] btn;
    int           hold;
    logic [N-1:0] lvl;
    int           p, r, l, rp;
  } vec_t;

  vec_t vecs [7];

  initial begin : watchdog
    #2_000_000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1, "watchdog expired");
  end

  initial begin : main
    int n, rel;
    logic [N-1:0] seen;
    logic [31:0] lmask, rmask;
    int cnt_a, cnt_b;
    bit released;

    bus.BTN = '0;
    do_reset();

    // Reset state
    chk("rst_level",   int'(bus.BTN_LEVEL),   0);
    chk("rst_press",   int'(bus.BTN_PRESS),   0);
    chk("rst_release", int'(bus.BTN_RELEASE), 0);
    chk("rst_long",    int'(bus.BTN_LONG),    0);
    chk("rst_repeat",  int'(bus.BTN_REPEAT),  0);
    $display("[reset] outputs level=%b press=%b", bus.BTN_LEVEL, bus.BTN_PRESS);

    // Clean press on channel 0
    bus.BTN = 3'b001;
    wait_press(3'b111, n, seen, rel);
    chk("clean_latency", n, 6);
    chk("clean_press_vec", int'(seen), 1);
    chk("clean_level", int'(bus.BTN_LEVEL), 1);
    tick();
    chk("clean_press_width", int'(bus.BTN_PRESS), 0);
    $display("[clean_press] latency=%0d press=%b", n, seen);

    // Bounce on channel 1
    do_reset();
    cnt_a = 0;
    for (int k = 0; k < 4; k++) begin
      bus.BTN[1] = (k % 2 == 0);
      tick();
      cnt_a += $countones(bus.BTN_PRESS | bus.BTN_RELEASE | bus.BTN_LEVEL);
    end
    bus.BTN[1] = 1'b1;
    wait_press(3'b111, n, seen, rel);
    cnt_a += rel;
    chk("bounce_quiet", cnt_a, 0);
    chk("bounce_latency", n, 6);
    chk("bounce_press_vec", int'(seen), 2);
    $display("[bounce] latency=%0d press=%b", n, seen);

    // Long press and repeat on channel 2
    do_reset();
    bus.BTN = 3'b100;
    wait_press(3'b100, n, seen, rel);
    chk("long_press_latency", n, 6);
    lmask = '0;
    rmask = '0;
    for (int i = 1; i <= 30; i++) begin
      tick();
      lmask[i] = bus.BTN_LONG[2];
      rmask[i] = bus.BTN_REPEAT[2];
    end
    chk("long_mask", int'(lmask), 32'h0000_0400);
    chk("repeat_mask", int'(rmask), 32'h1249_2000);
    bus.BTN = 3'b000;
    cnt_a = 0;
    cnt_b = 0;
    released = 1'b0;
    for (int i = 1; i <= 20; i++) begin
      tick();
      if (released) cnt_b += bus.BTN_REPEAT[2];
      cnt_a += bus.BTN_RELEASE[2];
      if (bus.BTN_RELEASE[2]) released = 1'b1;
    end
    chk("long_release_count", cnt_a, 1);
    chk("long_repeat_after_release", cnt_b, 0);
    $display("[long_repeat] long=%h repeat=%h releases=%0d", lmask, rmask, cnt_a);

    // Accepted fall coincides with the long threshold
    do_reset();
    bus.BTN = 3'b001;
    wait_press(3'b001, n, seen, rel);
    for (int i = 0; i < 4; i++) tick();
    bus.BTN = 3'b000;
    cnt_a = 0;
    for (int i = 0; i < 6; i++) begin
      tick();
      cnt_a += bus.BTN_LONG[0];
    end
    chk("thr_release", int'(bus.BTN_RELEASE[0]), 1);
    chk("thr_level", int'(bus.BTN_LEVEL[0]), 0);
    for (int i = 0; i < 15; i++) begin
      tick();
      cnt_a += bus.BTN_LONG[0] + bus.BTN_REPEAT[0];
    end
    chk("thr_no_long", cnt_a, 0);
    bus.BTN = 3'b001;
    wait_press(3'b001, n, seen, rel);
    chk("thr_repress_latency", n, 6);
    lmask = '0;
    for (int i = 1; i <= 12; i++) begin
      tick();
      lmask[i] = bus.BTN_LONG[0];
    end
    chk("thr_repress_long", int'(lmask), 32'h0000_0400);
    $display("[release_at_threshold] long_count=%0d repress_long=%h", cnt_a, lmask);

    // Asynchronous reset while auto-repeating
    do_reset();
    bus.BTN = 3'b111;
    wait_press(3'b111, n, seen, rel);
    for (int i = 0; i < 16; i++) tick();
    chk("rmid_repeat_before", int'(bus.BTN_REPEAT), 7);
    rst = 1'b1;
    #1;
    chk("rmid_level",   int'(bus.BTN_LEVEL),   0);
    chk("rmid_repeat",  int'(bus.BTN_REPEAT),  0);
    chk("rmid_press",   int'(bus.BTN_PRESS),   0);
    chk("rmid_release", int'(bus.BTN_RELEASE), 0);
    chk("rmid_long",    int'(bus.BTN_LONG),    0);
    tick();
    tick();
    rst = 1'b0;
    wait_press(3'b111, n, seen, rel);
    chk("rmid_press_latency", n, 6);
    chk("rmid_press_vec", int'(seen), 7);
    chk("rmid_no_release", rel, 0);
    $display("[reset_mid_hold] latency=%0d press=%b releases=%0d", n, seen, rel);

    // Simultaneous press on channels 0 and 2
    do_reset();
    bus.BTN = 3'b101;
    wait_press(3'b111, n, seen, rel);
    chk("sim_latency", n, 6);
    chk("sim_press_vec", int'(seen), 5);
    n = -1;
    seen = '0;
    for (int i = 1; i <= 12; i++) begin
      tick();
      if (bus.BTN_LONG != '0 && n < 0) begin
        n = i;
        seen = bus.BTN_LONG;
      end
    end
    chk("sim_long_delay", n, 10);
    chk("sim_long_vec", int'(seen), 5);
    $display("[simultaneous] long_delay=%0d long=%b", n, seen);

    // Table of multi-channel vectors: strobe counts per window and final level
    vecs[0] = '{3'b001, 8,  3'b001, 1, 0, 0, 0};
    vecs[1] = '{3'b011, 3,  3'b001, 0, 0, 0, 0};
    vecs[2] = '{3'b011, 10, 3'b011, 1, 0, 1, 1};
    vecs[3] = '{3'b010, 6,  3'b010, 0, 1, 1, 3};
    vecs[4] = '{3'b000, 8,  3'b000, 0, 1, 0, 1};
    vecs[5] = '{3'b100, 2,  3'b000, 0, 0, 0, 0};
    vecs[6] = '{3'b000, 8,  3'b000, 0, 0, 0, 0};
    do_reset();
    for (int v = 0; v < 7; v++) begin
      int p, r, l, rp;
      p = 0; r = 0; l = 0; rp = 0;
      bus.BTN = vecs[v].btn;
      for (int i = 0; i < vecs[v].hold; i++) begin
        tick();
        p  += $countones(bus.BTN_PRESS);
        r  += $countones(bus.BTN_RELEASE);
        l  += $countones(bus.BTN_LONG);
        rp += $countones(bus.BTN_REPEAT);
      end
      chk($sformatf("vec%0d_level", v),   int'(bus.BTN_LEVEL), int'(vecs[v].lvl));
      chk($sformatf("vec%0d_press", v),   p,  vecs[v].p);
      chk($sformatf("vec%0d_release", v), r,  vecs[v].r);
      chk($sformatf("vec%0d_long", v),    l,  vecs[v].l);
      chk($sformatf("vec%0d_repeat", v),  rp, vecs[v].rp);
      $display("[vec%0d] btn=%b hold=%0d level=%b p=%0d r=%0d l=%0d rp=%0d",
               v, vecs[v].btn, vecs[v].hold, bus.BTN_LEVEL, p, r, l, rp);
    end

    // Random segments, checked cycle by cycle against the model
    do_reset();
    for (int s = 0; s < 80; s++) begin
      int hold;
      logic [N-1:0] val;
      if ($urandom_range(0, 15) == 0) begin
        rst = 1'b1;
        tick();
        rst = 1'b0;
      end
      val  = N'($urandom_range(0, 7));
      hold = $urandom_range(1, 30);
      bus.BTN = val;
      for (int i = 0; i < hold; i++) tick();
      $display("[rand%0d] btn=%b hold=%0d level=%b", s, val, hold, bus.BTN_LEVEL);
    end

    tick();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/btn_conditioner.md
# btn_conditioner

Input-side conditioner for the board push-buttons (BTNC, BTNL, BTNR, plus any future buttons). It takes the raw, asynchronous, bouncing button pins and produces clean debounced levels and single-cycle event strobes: press, release, long-press and auto-repeat. Downstream logic, such as the 7-segment and RGB LED drivers, consumes these strobes instead of sampling the raw pins.

## Interface
Parameters:
- N_BTN, 3, number of button channels.
- DEBOUNCE_CYCLES, 1_000_000, consecutive stable cycles needed to accept a level change (10 ms at 100 MHz); minimum 2.
- LONG_CYCLES, 50_000_000, held cycles after the press strobe before the long-press strobe (0.5 s); minimum 2.
- REPEAT_CYCLES, 10_000_000, period of repeat strobes after a long press (0.1 s); minimum 2.

Ports:
- CLK100MHZ  in  1  system clock; the only clock.
- RST  in  1  reset, asynchronous, active-high.
- BTN  in  N_BTN  raw button pins; asynchronous; 1 = pressed.
- BTN_LEVEL  out  N_BTN  debounced level per button.
- BTN_PRESS  out  N_BTN  one-cycle strobe on each accepted 0→1.
- BTN_RELEASE  out  N_BTN  one-cycle strobe on each accepted 1→0.
- BTN_LONG  out  N_BTN  one-cycle strobe when a hold reaches LONG_CYCLES.
- BTN_REPEAT  out  N_BTN  one-cycle strobe every REPEAT_CYCLES after BTN_LONG while the button is still held.

## Operation
- Channels are fully independent. No cross-channel priority or interaction.
- Synchronizer: 2-FF per bit, reset to 0.
- Debounce counter, width $clog2(DEBOUNCE_CYCLES):
  - Counts cycles in which the synchronized bit ≠ BTN_LEVEL.
  - Clears to 0 on any cycle in which they are equal. A single glitch restarts the count.
  - On a mismatch cycle with count = DEBOUNCE_CYCLES-1: BTN_LEVEL toggles at the next edge and the counter clears.
- Hold FSM per channel, states IDLE, DOWN, RPT:
  - IDLE → DOWN on accepted rise. BTN_PRESS asserts in the same cycle BTN_LEVEL first reads 1. Hold counter clears.
  - DOWN: hold counter increments each cycle. At count = LONG_CYCLES-1: BTN_LONG pulses, hold counter clears, state → RPT.
  - RPT: hold counter increments. At count = REPEAT_CYCLES-1: BTN_REPEAT pulses and the counter clears. Stays in RPT.
  - DOWN or RPT → IDLE on accepted fall. BTN_RELEASE asserts in the same cycle BTN_LEVEL first reads 0. Hold counter clears.
- Hold counter width: $clog2(max(LONG_CYCLES, REPEAT_CYCLES)). It never wraps; it is cleared at each threshold.
- Simultaneous events:
  - A fall accepted in the same cycle the LONG or REPEAT threshold would hit: release wins. Only BTN_RELEASE pulses; no LONG or REPEAT that cycle.
  - BTN_PRESS and BTN_RELEASE are never high together on one channel.
- Reset values: all outputs 0, all counters 0, FSM in IDLE. Applies immediately on RST assertion, asynchronously, including mid-debounce or mid-hold.
  - No strobes are produced on the release of reset, even if a button is held. A held button is accepted only after the full debounce interval.

## Timing
- Raw edge to BTN_LEVEL change and strobe: 2 sync cycles + DEBOUNCE_CYCLES cycles, provided the input is stable throughout.
- BTN_PRESS to BTN_LONG: exactly LONG_CYCLES cycles.
- BTN_LONG to first BTN_REPEAT: exactly REPEAT_CYCLES cycles. Repeat period thereafter: REPEAT_CYCLES.
- All outputs are registered. No combinational path from BTN to any output.

## Structure
- Package btn_pkg:
  - Typedef btn_state_t enum {IDLE, DOWN, RPT}.
  - Default constants DEBOUNCE_CYCLES_DEF, LONG_CYCLES_DEF, REPEAT_CYCLES_DEF.
- Sub-module btn_channel: one button's synchronizer, debounce counter and hold FSM, with scalar ports.
- btn_conditioner is a generate loop of N_BTN btn_channel instances.
- Parameter minimums are checked with an elaboration-time assertion.

## Test plan
Bench parameters: DEBOUNCE_CYCLES=4, LONG_CYCLES=10, REPEAT_CYCLES=3, N_BTN=3.
- Clean press: BTN[0] 0→1 and held → BTN_LEVEL[0]=1 and BTN_PRESS[0] one-cycle pulse exactly 6 cycles after the edge; channels 1 and 2 stay 0.
- Bounce: BTN[1] toggles 1,0,1,0 on alternate cycles, then stays 1 → no strobe during the bounce; BTN_PRESS[1] 6 cycles after the last edge.
- Long and repeat: hold BTN[2] for 30 cycles after BTN_PRESS[2] → BTN_LONG[2] at +10; BTN_REPEAT[2] at +13, +16, +19, +22, +25, +28; release → one BTN_RELEASE[2], and repeats stop.
- Release at threshold: timing arranged so the accepted fall lands on the LONG_CYCLES-1 cycle → BTN_RELEASE pulses, BTN_LONG stays 0, FSM returns to IDLE.
- Reset mid-hold: assert RST in RPT → all outputs 0 within the same cycle. Deassert with BTN held → BTN_PRESS exactly 6 cycles later, no spurious RELEASE.
- Simultaneous channels: BTN[0] and BTN[2] pressed on the same cycle → both BTN_PRESS strobes in the same cycle; BTN_LONG for both 10 cycles later.
